// File: rtl/feedback_check_ctrl.sv
// Sequencer for the feedback shift-register checker core: screens the candidate's flag
// format, loads the core, steps it until a match or the step budget runs out, then reports the result.
module feedback_check_ctrl #(
    parameter int          WIDTH          = 256,
    parameter int          MAX_STEPS      = 128000,
    parameter int          PROGRESS_STEPS = 12800,
    parameter logic [39:0] PREFIX         = 40'h696374667b,
    parameter logic [7:0]  SUFFIX         = 8'h7d
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             core_load,
    output logic [WIDTH-1:0] core_init,
    output logic             core_step,
    input  logic             core_match,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_code,
    output logic [23:0]      res_steps,
    output logic             busy,
    output logic             progress_tick
);

    localparam logic [23:0] MAX_CNT   = 24'(MAX_STEPS);
    localparam logic [23:0] PROG_LAST = 24'(PROGRESS_STEPS - 1);

    localparam logic [1:0] CODE_PASS    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_BADFMT  = 2'b10;
    localparam logic [1:0] CODE_ABORT   = 2'b11;

    // The step counter is 24 bits and must never wrap.
    generate
        if (MAX_STEPS < 1 || MAX_STEPS > 24'hFFFFFF) begin : g_bad_max_steps
            $error("MAX_STEPS must be in 1..2^24-1");
        end
        if (PROGRESS_STEPS < 1 || PROGRESS_STEPS > 24'hFFFFFF) begin : g_bad_progress
            $error("PROGRESS_STEPS must be in 1..2^24-1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state_reg;
    logic [23:0]      steps_reg;
    logic [23:0]      prog_cnt_reg;
    logic [WIDTH-1:0] core_init_reg;
    logic             in_ready_reg;
    logic             core_load_reg;
    logic             res_valid_reg;
    logic [1:0]       res_code_reg;
    logic             busy_reg;
    logic             progress_tick_reg;

    // Flag format: five prefix bytes at the top of the candidate, one suffix byte at the bottom.
    logic [4:0] prefix_hit;
    logic       format_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_prefix
            assign prefix_hit[gi] = (in_data[WIDTH-40+8*gi +: 8] == PREFIX[8*gi +: 8]);
        end
    endgenerate

    assign format_ok = (&prefix_hit) && (in_data[7:0] == SUFFIX);

    // Never step on a cycle where a match is visible, so the reported count is exact.
    logic step_now;
    assign step_now = (state_reg == RUN) && !abort && !core_match && (steps_reg < MAX_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            steps_reg         <= '0;
            prog_cnt_reg      <= '0;
            core_init_reg     <= '0;
            in_ready_reg      <= 1'b1;
            core_load_reg     <= 1'b0;
            res_valid_reg     <= 1'b0;
            res_code_reg      <= 2'b00;
            busy_reg          <= 1'b0;
            progress_tick_reg <= 1'b0;
        end else begin
            core_load_reg     <= 1'b0;
            progress_tick_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        core_init_reg <= in_data;
                        in_ready_reg  <= 1'b0;
                        if (format_ok) begin
                            state_reg     <= LOAD;
                            core_load_reg <= 1'b1;
                            busy_reg      <= 1'b1;
                        end else begin
                            state_reg     <= DONE;
                            res_valid_reg <= 1'b1;
                            res_code_reg  <= CODE_BADFMT;
                        end
                    end
                end
                LOAD: begin
                    // The load strobe has already gone out; abort only skips the run.
                    if (abort) begin
                        state_reg     <= DONE;
                        res_valid_reg <= 1'b1;
                        res_code_reg  <= CODE_ABORT;
                        busy_reg      <= 1'b0;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (abort || core_match || steps_reg == MAX_CNT) begin
                        state_reg     <= DONE;
                        res_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        if (abort)
                            res_code_reg <= CODE_ABORT;
                        else if (core_match)
                            res_code_reg <= CODE_PASS;
                        else
                            res_code_reg <= CODE_TIMEOUT;
                    end else begin
                        steps_reg <= steps_reg + 24'd1;
                        if (prog_cnt_reg == PROG_LAST) begin
                            prog_cnt_reg      <= '0;
                            progress_tick_reg <= 1'b1;
                        end else begin
                            prog_cnt_reg <= prog_cnt_reg + 24'd1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        res_code_reg  <= 2'b00;
                        steps_reg     <= '0;
                        prog_cnt_reg  <= '0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_reg;
    assign core_load     = core_load_reg;
    assign core_init     = core_init_reg;
    assign core_step     = step_now;
    assign res_valid     = res_valid_reg;
    assign res_code      = res_code_reg;
    assign res_steps     = steps_reg;
    assign busy          = busy_reg;
    assign progress_tick = progress_tick_reg;

endmodule

// File: doc/feedback_check_ctrl.md
Name: feedback_check_ctrl

Overview:
- Sequencer for the 256-bit feedback shift-register checker core. Does not compute feedback itself.
- Accepts a candidate over a valid/ready handshake and pre-screens the flag format.
- Loads the candidate into the core, then steps the core until its match flag asserts or a step budget runs out.
- Returns a result code and step count to the host over a second valid/ready handshake.

Parameters:
- WIDTH, 256, candidate/core state width
- MAX_STEPS, 128000, step budget (500 full rotations of 256)
- PROGRESS_STEPS, 12800, steps between progress_tick pulses
- PREFIX, 40'h696374667b, required value of cand[WIDTH-1:WIDTH-40] ("ictf{")
- SUFFIX, 8'h7d, required value of cand[7:0] ("}")

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  candidate valid
- in_ready  out  1  controller can accept a candidate
- in_data  in  WIDTH  candidate value
- abort  in  1  cancel the check in progress
- core_load  out  1  one-cycle load strobe to the core
- core_init  out  WIDTH  value loaded into the core; held stable from acceptance to the next acceptance
- core_step  out  1  core advances one shift on each clk where this is high
- core_match  in  1  combinational: core state equals the target
- res_valid  out  1  result available
- res_ready  in  1  host consumes the result
- res_code  out  2  00 pass, 01 timeout, 10 bad format, 11 aborted
- res_steps  out  24  number of core_step pulses issued before the result
- busy  out  1  high in LOAD or RUN
- progress_tick  out  1  one-cycle pulse every PROGRESS_STEPS steps

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; steps=0; core_init=0.
  - in_ready=1; all other outputs 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into core_init.
  - If PREFIX and SUFFIX both match: go to LOAD.
  - Otherwise: go to DONE with res_code=10, res_steps=0. The core is never loaded.
- LOAD:
  - core_load=1 for exactly one cycle; in_ready=0.
  - Next state RUN; the core holds core_init from the next cycle.
- RUN, evaluated each cycle in priority order:
  1. abort -> DONE with code 11.
  2. core_match -> DONE with code 00.
  3. steps==MAX_STEPS -> DONE with code 01.
  4. Otherwise: core_step=1, steps<=steps+1.
- core_step is combinational: it is high only in RUN, when !abort, !core_match and steps<MAX_STEPS. No step is ever issued on the cycle a match is seen.
- A candidate whose loaded value already matches completes with res_steps=0, exactly one cycle after LOAD.
- Latency:
  - Pass after k steps: res_valid rises k+2 cycles after the accept edge.
  - Timeout: res_valid rises MAX_STEPS+2 cycles after the accept edge.
- progress_tick: pulses in the cycle after steps transitions to a nonzero multiple of PROGRESS_STEPS.
- DONE:
  - res_valid=1; res_code and res_steps held stable.
  - On res_ready: go to IDLE and clear steps. res_valid drops the following cycle.
  - in_ready=0 throughout DONE; no new candidate is accepted in the same cycle as the result handshake.
- abort:
  - Ignored in IDLE and DONE.
  - In LOAD: core_load still pulses; the FSM goes to DONE with code 11 and res_steps=0.
  - Aborted results report the steps already issued.
- Step counter: 24-bit, never wraps. MAX_STEPS must be ≤ 2^24-1; the implementation checks this at elaboration.
- reset_n asserted mid-check: immediate return to IDLE with every output at its reset value. No result is produced for the interrupted candidate.
- busy = (state==LOAD)||(state==RUN).

Test Plan:
- Accept cand=0x696374667b00…007d. Model the core as a real LFSR whose target matches after 300 shifts -> exactly 300 core_step pulses, res_code=00, res_steps=300, res_valid at accept+302 cycles.
- Accept cand with top byte 0x68 (bad prefix) -> no core_load pulse; res_code=10, res_steps=0 one cycle after accept.
- core_match tied 0, MAX_STEPS overridden to 512, PROGRESS_STEPS to 128 -> res_code=01, res_steps=512, progress_tick pulses exactly 4 times.
- core_match=1 immediately after LOAD -> res_code=00, res_steps=0, zero core_step pulses.
- abort on the 50th RUN cycle -> res_code=11, res_steps=49; hold res_ready=0 for 10 cycles -> outputs stable throughout.
- reset_n low for 1 cycle mid-RUN -> core_step drops immediately, in_ready=1 after release; a following valid candidate completes normally.
